// File: rtl/adder_unit.sv
// adder_unit: registered two's-complement adder/subtractor with a two-level
// carry-lookahead datapath (GROUP-bit groups, lookahead across groups).
// Optional flag outputs (carry, overflow, zero, negative) are built only when
// the ADDER_FLAGS_EN macro is defined.
module adder_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] o
`ifdef ADDER_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
`endif
);

  localparam int unsigned NG = (WIDTH + GROUP - 1) / GROUP;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] o_q, o_d;

`ifdef ADDER_FLAGS_EN
  logic cmsb_c;
  logic carry_q, carry_d;
  logic overflow_q, overflow_d;
  logic zero_q, zero_d;
  logic negative_q, negative_d;
`endif

  // Per-bit generate/propagate on the (possibly inverted) B operand.
  always_comb begin
    b_eff = b ^ {WIDTH{sub}};
    g     = a & b_eff;
    p     = a ^ b_eff;
  end

  // First level: group generate/propagate; the last group may be partial.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < int'(NG); j++) begin
      logic gt;
      logic pt;
      gt = 1'b0;
      pt = 1'b1;
      for (int k = 0; k < int'(GROUP); k++) begin
        int idx;
        idx = j * int'(GROUP) + k;
        if (idx < int'(WIDTH)) begin
          gt = g[idx] | (p[idx] & gt);
          pt = pt & p[idx];
        end
      end
      grp_g[j] = gt;
      grp_p[j] = pt;
    end
  end

  // Second level: carry into each group from group G/P and the subtract carry-in.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = sub;
    for (int j = 0; j < int'(NG); j++) begin
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
    end
    cout_c = grp_c[NG];
  end

  // Bit carries inside each group seeded by the group carry-in; sum bits.
  always_comb begin
    sum_c = '0;
`ifdef ADDER_FLAGS_EN
    cmsb_c = 1'b0;
`endif
    for (int j = 0; j < int'(NG); j++) begin
      logic cc;
      cc = grp_c[j];
      for (int k = 0; k < int'(GROUP); k++) begin
        int idx;
        idx = j * int'(GROUP) + k;
        if (idx < int'(WIDTH)) begin
          sum_c[idx] = p[idx] ^ cc;
`ifdef ADDER_FLAGS_EN
          if (idx == int'(WIDTH) - 1) cmsb_c = cc;
`endif
          cc = g[idx] | (p[idx] & cc);
        end
      end
    end
  end

  // Capture a new result on valid input, otherwise hold the last one.
  always_comb begin
    out_valid_d = in_valid;
    o_d         = o_q;
`ifdef ADDER_FLAGS_EN
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
`endif
    if (in_valid) begin
      o_d = sum_c;
`ifdef ADDER_FLAGS_EN
      carry_d    = cout_c;
      overflow_d = cmsb_c ^ cout_c;
      zero_d     = ~|sum_c;
      negative_d = sum_c[WIDTH-1];
`endif
    end
  end

  // Output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      o_q         <= '0;
`ifdef ADDER_FLAGS_EN
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      o_q         <= o_d;
`ifdef ADDER_FLAGS_EN
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign o         = o_q;
`ifdef ADDER_FLAGS_EN
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;
`else
  // Carry out of the MSB only feeds the optional flags.
  logic unused_cout;
  assign unused_cout = cout_c;
`endif

endmodule

// File: tb/tb_adder_unit.sv
// Bench for adder_unit: a 32-bit instance (GROUP=4) and an 8-bit instance
// with a partial last group (GROUP=3). Flag checks are built with ADDER_FLAGS_EN.
module tb_adder_unit;

  typedef struct {
    logic [31:0] o;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_o;
    logic        exp_c;
    logic        exp_v;
    logic        exp_z;
    logic        exp_n;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        sub;
  logic        ov32, ov8;
  logic [31:0] o32;
  logic [7:0]  o8;
`ifdef ADDER_FLAGS_EN
  logic c32, v32, z32, n32;
  logic c8, v8, z8, n8;
`endif

  int tests;
  int fails;

  res_t exp32, exp8;

  adder_unit #(.WIDTH(32), .GROUP(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a32), .b(b32), .sub(sub),
    .out_valid(ov32), .o(o32)
`ifdef ADDER_FLAGS_EN
    , .carry(c32), .overflow(v32), .zero(z32), .negative(n32)
`endif
  );

  adder_unit #(.WIDTH(8), .GROUP(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a8), .b(b8), .sub(sub),
    .out_valid(ov8), .o(o8)
`ifdef ADDER_FLAGS_EN
    , .carry(c8), .overflow(v8), .zero(z8), .negative(n8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic at width w.
  function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic s);
    res_t r;
    longint m, ua, ub, sa, sb, full, sr, half;
    m    = (longint'(1) <<< w) - 1;
    half = longint'(1) <<< (w - 1);
    ua   = longint'({32'd0, a}) & m;
    ub   = longint'({32'd0, b}) & m;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    full = s ? ua - ub : ua + ub;
    r.o  = 32'(full & m);
    r.c  = s ? (ua >= ub) : (((ua + ub) >>> w) != 0);
    sr   = s ? sa - sb : sa + sb;
    r.v  = (sr >= half) || (sr < -half);
    r.z  = (r.o == 32'd0);
    r.n  = r.o[w-1];
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called just after a rising edge).
  task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic s);
    in_valid = v;
    a32 = a;
    b32 = b;
    a8  = a[7:0];
    b8  = b[7:0];
    sub = s;
    if (v) begin
      exp32 = model(32, a, b, s);
      exp8  = model(8, a, b, s);
    end
  endtask

  task automatic check_both(string tag, logic v);
    chk({tag, " o32"}, o32, exp32.o);
    chk({tag, " ov32"}, 32'(ov32), 32'(v));
    chk({tag, " o8"}, 32'(o8), exp8.o);
    chk({tag, " ov8"}, 32'(ov8), 32'(v));
`ifdef ADDER_FLAGS_EN
    chk({tag, " c32"}, 32'(c32), 32'(exp32.c));
    chk({tag, " v32"}, 32'(v32), 32'(exp32.v));
    chk({tag, " z32"}, 32'(z32), 32'(exp32.z));
    chk({tag, " n32"}, 32'(n32), 32'(exp32.n));
    chk({tag, " c8"}, 32'(c8), 32'(exp8.c));
    chk({tag, " v8"}, 32'(v8), 32'(exp8.v));
    chk({tag, " z8"}, 32'(z8), 32'(exp8.z));
    chk({tag, " n8"}, 32'(n8), 32'(exp8.n));
`endif
  endtask

  vec_t vecs[8];

  initial begin
    tests = 0;
    fails = 0;
    exp32 = '{o: 32'd0, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
    exp8  = exp32;

    vecs[0] = '{32'd20,        32'd7,  1'b0, 32'd27,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd20,        32'd7,  1'b1, 32'd13,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'd7,         32'd20, 1'b1, 32'hFFFFFFF3,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'hFFFFFFD1,  32'd30, 1'b0, 32'hFFFFFFEF,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFFFFD1,  32'd30, 1'b1, 32'hFFFFFFB3,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h7FFFFFFF,  32'd1,  1'b0, 32'h80000000,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'hFFFFFFFF,  32'd1,  1'b0, 32'h00000000,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h80000000,  32'd1,  1'b1, 32'h7FFFFFFF,  1'b1, 1'b1, 1'b0, 1'b0};

    // Reset held with valid operands present: outputs stay cleared.
    rst_n = 1'b0;
    drive(1'b1, 32'd5, 32'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst o32", o32, 32'd0);
    chk("rst ov32", 32'(ov32), 32'd0);
    chk("rst o8", 32'(o8), 32'd0);
    chk("rst ov8", 32'(ov8), 32'd0);
`ifdef ADDER_FLAGS_EN
    chk("rst flags32", {28'd0, c32, v32, z32, n32}, 32'd0);
    chk("rst flags8", {28'd0, c8, v8, z8, n8}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first o32", o32, 32'd8);
    check_both("first", 1'b1);

    // Directed table, applied back to back.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d o", i), o32, vecs[i].exp_o);
      chk($sformatf("vec%0d valid", i), 32'(ov32), 32'd1);
`ifdef ADDER_FLAGS_EN
      chk($sformatf("vec%0d flags", i), {28'd0, c32, v32, z32, n32},
          {28'd0, vecs[i].exp_c, vecs[i].exp_v, vecs[i].exp_z, vecs[i].exp_n});
`endif
      check_both($sformatf("vec%0d", i), 1'b1);
    end

    // Valid gap: result held, X on idle inputs ignored.
    drive(1'b1, 32'd4, 32'd5, 1'b0);
    @(posedge clk); #1;
    chk("hold a o32", o32, 32'd9);
    check_both("hold a", 1'b1);
    drive(1'b0, 32'hx, 32'hx, 1'bx);
    @(posedge clk); #1;
    chk("hold gap o32", o32, 32'd9);
    check_both("hold gap", 1'b0);
    drive(1'b1, 32'd6, 32'd2, 1'b1);
    @(posedge clk); #1;
    chk("hold b o32", o32, 32'd4);
    check_both("hold b", 1'b1);

    // Asynchronous reset between edges clears without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async o32", o32, 32'd0);
    chk("async ov32", 32'(ov32), 32'd0);
    chk("async o8", 32'(o8), 32'd0);
`ifdef ADDER_FLAGS_EN
    chk("async flags32", {28'd0, c32, v32, z32, n32}, 32'd0);
`endif
    exp32 = '{o: 32'd0, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
    exp8  = exp32;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_both("post rst idle", 1'b0);

    // Random small signed operands with occasional idle cycles.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic        rv, rs;
      ra = 32'($urandom_range(98)) - 32'd49;
      rb = 32'($urandom_range(98)) - 32'd49;
      rs = 1'($urandom_range(1));
      rv = ($urandom_range(4) != 0);
      drive(rv, ra, rb, rs);
      @(posedge clk); #1;
      check_both($sformatf("rnd%0d", i), rv);
    end

    // Full-range random operands, back to back.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(1)));
      @(posedge clk); #1;
      check_both($sformatf("wide%0d", i), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
